// File: rtl/sha3_absorb_ctrl_if.sv
// Message-source / permutation-core bus of the SHA3-256 absorb controller.
// The master modport is the side that supplies words and acknowledges blocks.
interface sha3_absorb_ctrl_if;
  logic [63:0]   in;
  logic          in_ready;
  logic          is_last;
  logic [3:0]    byte_num;
  logic          buffer_full;
  logic [1087:0] out;
  logic          out_ready;
  logic          last_block;
  logic          f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, last_block
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, last_block
  );
endinterface

// File: rtl/sha3_absorb_ctrl.sv
// SHA3-256 absorb controller: packs 64-bit message words into 17-word rate
// blocks, applies 0x06 ... 0x80 padding and hands blocks to the Keccak core.
module sha3_absorb_ctrl (
  input  logic               clk,
  input  logic               reset,
  sha3_absorb_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [4:0]      cnt_r, cnt_s;
  logic [1087:0]   out_r, out_s;
  logic            pad_first_r, pad_first_s;
  logic            last_seen_r, last_seen_s;
  logic            last_block_r, last_block_s;
  logic            out_ready_r;
  logic            buffer_full_r;
  logic            ins_s;
  logic [63:0]     ins_word_s;
  logic [3:0]      n_s;

  // Keep the first n bytes, put the domain byte 0x06 at byte n, zero the rest.
  function automatic logic [63:0] pad_word(input logic [63:0] data, input logic [3:0] n);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) begin
        w[63-8*i -: 8] = data[63-8*i -: 8];
      end else if (i == int'(n)) begin
        w[63-8*i -: 8] = 8'h06;
      end else begin
        w[63-8*i -: 8] = 8'h00;
      end
    end
    return w;
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_FILL;
      cnt_r         <= 5'd0;
      out_r         <= '0;
      pad_first_r   <= 1'b0;
      last_seen_r   <= 1'b0;
      last_block_r  <= 1'b0;
      out_ready_r   <= 1'b0;
      buffer_full_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      out_r         <= out_s;
      pad_first_r   <= pad_first_s;
      last_seen_r   <= last_seen_s;
      last_block_r  <= last_block_s;
      out_ready_r   <= (state_s == ST_FULL);
      buffer_full_r <= (state_s != ST_FILL);
    end
  end

  // Next-state, word insertion and padding decisions.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    out_s        = out_r;
    pad_first_s  = pad_first_r;
    last_seen_s  = last_seen_r;
    last_block_s = last_block_r;
    ins_s        = 1'b0;
    ins_word_s   = 64'd0;
    n_s          = (bus.byte_num > 4'd8) ? 4'd8 : bus.byte_num;

    case (state_r)
      ST_FILL: begin
        if (bus.in_ready && !buffer_full_r) begin
          ins_s = 1'b1;
          if (bus.is_last) begin
            // A full last word defers the 0x06 byte to the next inserted word.
            last_seen_s = 1'b1;
            pad_first_s = (n_s == 4'd8);
            ins_word_s  = pad_word(bus.in, n_s) |
                          (((n_s != 4'd8) && (cnt_r == 5'd16)) ? 64'h0000_0000_0000_0080 : 64'd0);
            if (cnt_r == 5'd16) begin
              state_s      = ST_FULL;
              last_block_s = (n_s != 4'd8);
            end else begin
              state_s = ST_PAD;
            end
          end else begin
            ins_word_s = bus.in;
            if (cnt_r == 5'd16) begin
              state_s = ST_FULL;
            end else begin
              state_s = ST_FILL;
            end
          end
        end else begin
          ins_s = 1'b0;
        end
      end

      ST_PAD: begin
        ins_s       = 1'b1;
        pad_first_s = 1'b0;
        ins_word_s  = (pad_first_r ? 64'h0600_0000_0000_0000 : 64'd0) |
                      ((cnt_r == 5'd16) ? 64'h0000_0000_0000_0080 : 64'd0);
        if (cnt_r == 5'd16) begin
          state_s      = ST_FULL;
          last_block_s = !pad_first_s;
        end else begin
          state_s = ST_PAD;
        end
      end

      ST_FULL: begin
        if (bus.f_ack) begin
          cnt_s        = 5'd0;
          last_block_s = 1'b0;
          if (last_block_r) begin
            state_s = ST_DONE;
          end else if (last_seen_r) begin
            state_s = ST_PAD;
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          state_s = ST_FULL;
        end
      end

      ST_DONE: begin
        state_s = ST_DONE;
      end

      default: begin
        state_s = ST_FILL;
      end
    endcase

    if (ins_s) begin
      out_s = {out_r[1023:0], ins_word_s};
      cnt_s = cnt_r + 5'd1;
    end else begin
      out_s = out_r;
    end
  end

  assign bus.out         = out_r;
  assign bus.out_ready   = out_ready_r;
  assign bus.last_block  = last_block_r;
  assign bus.buffer_full = buffer_full_r;

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Scoreboard bench for sha3_absorb_ctrl: expected blocks come from byte-level
// SHA3 padding of each message; a monitor compares and acknowledges blocks.
module tb_sha3_absorb_ctrl;

  logic clk = 1'b0;
  logic reset;

  sha3_absorb_ctrl_if bus ();

  sha3_absorb_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [1087:0] exp_q[$];
  logic          exp_last_q[$];
  logic [63:0]   msg_q[$];
  logic [3:0]    last_n;
  int            last_acks = 0;
  bit            mon_en = 1'b0;
  bit            allow_idle = 1'b1;
  int            fix_delay = -1;

  logic [1087:0] snap;
  logic [1087:0] e_blk;
  logic          e_last;
  int            d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference: message bytes, then 0x06, zero fill to 136-byte multiple, 0x80 on the last byte.
  task automatic push_expected();
    logic [7:0]    bq[$];
    logic [1087:0] blk;
    int            nb;
    int            nblk;
    for (int i = 0; i < msg_q.size(); i++) begin
      nb = (i == msg_q.size() - 1) ? ((last_n > 4'd8) ? 8 : int'(last_n)) : 8;
      for (int b = 0; b < nb; b++) bq.push_back(msg_q[i][63-8*b -: 8]);
    end
    bq.push_back(8'h06);
    while ((bq.size() % 136) != 0) bq.push_back(8'h00);
    bq[bq.size()-1] = bq[bq.size()-1] | 8'h80;
    nblk = bq.size() / 136;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 136; j++) blk[1087-8*j -: 8] = bq[b*136 + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  task automatic drive_word(input logic [63:0] data, input logic lst, input logic [3:0] n, output bit ok);
    bit acc;
    ok = 1'b0;
    if (allow_idle && ($urandom_range(0, 3) == 0)) begin
      bus.in_ready = 1'b0;
      bus.in       = {$urandom, $urandom};
      bus.is_last  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.in       = data;
    bus.is_last  = lst;
    bus.byte_num = n;
    bus.in_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = !bus.buffer_full;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=buffer_full stuck expected=word accepted");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_ready", bus.out_ready, 1'b0);
    chk("rst_last_block", bus.last_block, 1'b0);
    chk("rst_buffer_full", bus.buffer_full, 1'b0);
    chk("rst_out_nonzero", |bus.out, 1'b0);
    reset = 1'b0;
  endtask

  task automatic run_msg();
    bit ok;
    bit lst;
    int k;
    int lat;
    int t;
    int target;
    push_expected();
    target = last_acks + 1;
    for (int i = 0; i < msg_q.size(); i++) begin
      lst = (i == msg_q.size() - 1);
      drive_word(msg_q[i], lst, lst ? last_n : 4'($urandom_range(0, 15)), ok);
      if (!ok) finish_now();
    end
    k = (msg_q.size() - 1) % 17;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_ready) break;
    end
    chk("pad_latency", 64'(lat), 64'(17 - k));
    t = 0;
    while ((last_acks < target) && (t < 400)) begin
      @(negedge clk);
      t++;
    end
    chk("final_block_seen", 64'(last_acks >= target), 64'd1);
    if (last_acks < target) finish_now();
    // DONE ignores the source and never raises out_ready again.
    bus.in       = {$urandom, $urandom};
    bus.is_last  = 1'b1;
    bus.byte_num = 4'd8;
    bus.in_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_buffer_full", bus.buffer_full, 1'b1);
      chk("done_out_ready", bus.out_ready, 1'b0);
    end
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    do_reset();
  endtask

  // Monitor: compare each presented block against the scoreboard, then acknowledge it.
  initial begin : monitor
    bus.f_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && bus.out_ready) begin
        bus.f_ack = 1'b0;
        snap = bus.out;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          e_last = 1'b0;
          $display("FAIL unexpected_block actual=out_ready expected=no pending block");
        end else begin
          e_blk  = exp_q.pop_front();
          e_last = exp_last_q.pop_front();
          for (int w = 0; w < 17; w++)
            chk($sformatf("block_word%0d", w), snap[1087-64*w -: 64], e_blk[1087-64*w -: 64]);
          chk("last_block", bus.last_block, e_last);
        end
        chk("full_buffer_full", bus.buffer_full, 1'b1);
        d = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 4));
        repeat (d) begin
          @(negedge clk);
          chk("out_stable", 64'(bus.out == snap), 64'd1);
          chk("ready_hold", bus.out_ready, 1'b1);
          chk("hold_buffer_full", bus.buffer_full, 1'b1);
        end
        bus.f_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.f_ack = 1'b0;
        @(negedge clk);
        chk("ready_drop", bus.out_ready, 1'b0);
        if (e_last) last_acks++;
      end else begin
        bus.f_ack = mon_en && !bus.out_ready && ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=still running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ok;
    reset        = 1'b1;
    bus.in       = 64'd0;
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    bus.byte_num = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_ready", bus.out_ready, 1'b0);
    chk("init_last_block", bus.last_block, 1'b0);
    chk("init_buffer_full", bus.buffer_full, 1'b0);
    chk("init_out_nonzero", |bus.out, 1'b0);
    reset = 1'b0;

    // Reset with 9 words buffered, then with a full block presented.
    for (int i = 0; i < 9; i++) begin
      drive_word({$urandom, $urandom}, 1'b0, 4'd0, ok);
      if (!ok) finish_now();
    end
    @(negedge clk);
    chk("partial_buffer_full", bus.buffer_full, 1'b0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_word({$urandom, $urandom}, 1'b0, 4'd0, ok);
      if (!ok) finish_now();
    end
    @(negedge clk);
    chk("block_out_ready", bus.out_ready, 1'b1);
    do_reset();
    mon_en = 1'b1;

    // Empty message.
    msg_q.delete();
    msg_q.push_back({$urandom, $urandom});
    last_n = 4'd0;
    run_msg();

    // Seven-byte last word landing in word 16.
    msg_q.delete();
    for (int i = 0; i < 16; i++) msg_q.push_back(64'h1111_1111_1111_1111);
    msg_q.push_back(64'h1234_5678_90AB_CDEF);
    last_n = 4'd7;
    run_msg();

    // Full last word at the end of a block: padding spills into a second block.
    msg_q.delete();
    for (int i = 0; i < 17; i++) msg_q.push_back({$urandom, $urandom});
    last_n = 4'd8;
    run_msg();

    // Continuous source with a slow permutation core.
    allow_idle = 1'b0;
    fix_delay  = 5;
    msg_q.delete();
    for (int i = 0; i < 40; i++) msg_q.push_back(64'(i + 1));
    last_n = 4'd5;
    run_msg();
    allow_idle = 1'b1;
    fix_delay  = -1;

    // Three-byte last word at position 5.
    msg_q.delete();
    for (int i = 0; i < 5; i++) msg_q.push_back({$urandom, $urandom});
    msg_q.push_back(64'h1234_56FF_FFFF_FFFF);
    last_n = 4'd3;
    run_msg();

    // Random messages, including out-of-range byte counts.
    for (int m = 0; m < 25; m++) begin
      msg_q.delete();
      for (int i = 0; i <= int'($urandom_range(0, 45)); i++) msg_q.push_back({$urandom, $urandom});
      last_n = 4'($urandom_range(0, 15));
      run_msg();
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    finish_now();
  end

endmodule

// File: doc/sha3_absorb_ctrl.md
# sha3_absorb_ctrl

SHA3-256 absorb-side controller. Accepts the message as a stream of 64-bit words, applies SHA3 padding (domain byte 0x06, final bit 0x80) on the last word, and packs words into 1088-bit rate blocks (17 words). It hands each block to the Keccak-f permutation core with an `out_ready`/`f_ack` handshake and applies backpressure to the message source while a block is pending or padding is in progress.

## Interface
Parameters:
- none. Rate is fixed at 17 words × 64 bits = 1088 bits for SHA3-256.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in`  in  64  message word; byte 0 is `in[63:56]`.
- `in_ready`  in  1  source has a valid word on `in`.
- `is_last`  in  1  qualifies `in`; this is the final message word.
- `byte_num`  in  4  valid bytes in the last word, 0..8; used only when `is_last` is 1; values 9..15 are treated as 8.
- `buffer_full`  out  1  word not accepted this cycle; the source must hold it.
- `out`  out  1088  rate block; word 0 is `out[1087:1024]` and word 16 is `out[63:0]`.
- `out_ready`  out  1  `out` holds a complete block.
- `last_block`  out  1  qualifies `out_ready`; this is the final padded block.
- `f_ack`  in  1  permutation core has consumed `out`.

## Operation
- Accept condition: `in_ready & ~buffer_full`. An accepted word shifts `out` left by 64 and enters at `out[63:0]`. The word counter `cnt` (0..17) increments.
- Padded last word for `byte_num` = n < 8:
  - bytes 0..n-1 come from `in`;
  - byte n = 0x06;
  - the remaining bytes are 0;
  - if this word lands at `cnt` = 16, byte 7 is OR'd with 0x80 (n = 7 gives 0x86).
- Full last word (n = 8): the word is inserted unchanged, and `pad_first` is set so the next inserted word is 0x0600_0000_0000_0000.
- States:
  - FILL: accept words. Non-last accept with `cnt` = 16 → FULL. Last accept → PAD, or FULL if `cnt` = 16.
  - PAD: insert one internally generated word per cycle, no input accepted. That word is 0x06<<56 if `pad_first` (then clear it), otherwise 0. The word at `cnt` = 16 is additionally OR'd with 0x80. When it is inserted: → FULL, and `last_block` is set if `pad_first` is now 0.
  - FULL: `out_ready` = 1. On `f_ack`, clear `cnt`. Then go to DONE if `last_block`; otherwise to PAD if padding is still owed (last word seen); otherwise to FILL.
  - DONE: `buffer_full` = 1 and `out_ready` = 0 until `reset`.
- `buffer_full` = 1 in every state except FILL.
- `f_ack` outside FULL is ignored. `in_ready` outside FILL is ignored.
- Only the final block carries the 0x80 bit. Padding never spans more than one extra block.

## Timing
- Reset values: `out` = 0, `out_ready` = 0, `last_block` = 0, `buffer_full` = 0; state FILL, `cnt` = 0, `pad_first` = 0.
- `out_ready` rises on the cycle after the 17th word (input or pad) is inserted.
- `out_ready` and `out` stay stable until `f_ack`. `out_ready` falls on the cycle after `f_ack` is sampled high.
- `buffer_full` falls on the cycle after `f_ack` when returning to FILL. The first new word can be accepted in that cycle.
- Pad latency: last word accepted at `cnt` = k gives `out_ready` high 17 − k cycles later.
- No combinational path from `in_ready` or `f_ack` to any output.
- Reset mid-block or mid-handshake drops the partial block. Outputs take reset values on the next edge.

## Test plan
- Empty message: `is_last` = 1, `byte_num` = 0 at cnt 0 → after 16 pad cycles, word0 = 0x0600000000000000, words 1..15 = 0, word16 = 0x0000000000000080, `last_block` = 1; after `f_ack`, state DONE and `buffer_full` stays 1.
- Partial word at end of block: 16 words 0x1111…, then `in` = 0x1234567890ABCDEF with `byte_num` = 7 → word16 = 0x1234567890ABCD86, `out_ready` on the next cycle, `last_block` = 1.
- Full last word at end of block: 17 words with `byte_num` = 8 on the last → first block has `last_block` = 0; after `f_ack`, a second block with word0 = 0x06<<56, zeros, word16 = 0x80, `last_block` = 1.
- Backpressure: hold `in_ready` = 1 with incrementing data, and delay `f_ack` 5 cycles → no word is lost or duplicated; `buffer_full` is high throughout FULL; word 17 of the stream appears as word0 of block 2.
- `byte_num` = 3 at cnt 5: word5 = 0x1234560600000000, words 6..15 = 0, word16 = 0x80; `out_ready` arrives 12 cycles after the accept.
- Reset asserted with `out_ready` = 1 and with 9 words buffered → all outputs return to 0 on the next edge; a fresh empty message then produces the correct block.
